// File: rtl/matcher_lane_scheduler.sv
// Round-robin seed dispatcher shared by NUM_LANES matcher engines.
// Hands a unique nonzero seed to each free lane, tracks outstanding jobs,
// counts match/pass results, latches the first hit and stops on a match
// target or an explicit stop command.
module matcher_lane_scheduler #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned SEED_WIDTH = 64,
    parameter int unsigned LANE_W     = 2
) (
    input  logic                  i_fclk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_counter_reset,
    input  logic [SEED_WIDTH-1:0] i_seed_base,
    input  logic [31:0]           i_match_target,
    output logic [NUM_LANES-1:0]  o_lane_start,
    output logic [SEED_WIDTH-1:0] o_lane_seed,
    input  logic [NUM_LANES-1:0]  i_lane_done,
    input  logic [NUM_LANES-1:0]  i_lane_match,
    output logic                  o_running,
    output logic                  o_finished,
    output logic                  o_first_hit_valid,
    output logic [LANE_W-1:0]     o_first_hit_lane,
    output logic [SEED_WIDTH-1:0] o_first_hit_seed,
    output logic                  o_err_spurious,
    output logic [31:0]           o_match_count,
    output logic [31:0]           o_pass_count
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDispatch = 2'd1,
        StDrain    = 2'd2,
        StDone     = 2'd3
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [SEED_WIDTH-1:0] r_seed;
    logic [NUM_LANES-1:0]  r_outstanding;
    logic [SEED_WIDTH-1:0] r_lane_seed [NUM_LANES];
    logic [LANE_W-1:0]     r_rr_ptr;
    logic [31:0]           r_match_count;
    logic [31:0]           r_pass_count;
    logic                  r_first_hit_valid;
    logic [LANE_W-1:0]     r_first_hit_lane;
    logic [SEED_WIDTH-1:0] r_first_hit_seed;
    logic                  r_err_spurious;

    logic [NUM_LANES-1:0]  w_qual;
    logic [NUM_LANES-1:0]  w_qual_match;
    logic [NUM_LANES-1:0]  w_qual_pass;
    logic [7:0]            w_match_pop;
    logic [7:0]            w_pass_pop;
    logic [32:0]           w_match_sum;
    logic [32:0]           w_pass_sum;
    logic [31:0]           w_match_next;
    logic [31:0]           w_pass_next;
    logic                  w_stop_now;
    logic                  w_grant_valid;
    logic [LANE_W-1:0]     w_grant_idx;
    logic [LANE_W-1:0]     w_scan_idx;
    logic [NUM_LANES-1:0]  w_grant_onehot;
    logic [LANE_W-1:0]     w_rr_next;
    logic [SEED_WIDTH-1:0] w_seed_inc;
    logic [SEED_WIDTH-1:0] w_seed_start;
    logic                  w_hit_any;
    logic [LANE_W-1:0]     w_hit_lane;
    logic                  w_start_ok;

    // Only done pulses on lanes with a job in flight are real results.
    assign w_qual       = i_lane_done & r_outstanding;
    assign w_qual_match = w_qual & i_lane_match;
    assign w_qual_pass  = w_qual & ~i_lane_match;
    assign w_hit_any    = |w_qual_match;
    assign w_start_ok   = (r_state == StIdle || r_state == StDone) && i_start;

    // Zero is reserved: a zero base starts at 1 and all-ones wraps to 1.
    assign w_seed_start = (i_seed_base == '0) ? SEED_WIDTH'(1) : i_seed_base;
    assign w_seed_inc   = (&r_seed) ? SEED_WIDTH'(1) : r_seed + SEED_WIDTH'(1);
    assign w_rr_next    = (w_grant_idx == LANE_W'(NUM_LANES - 1)) ? '0
                                                                  : w_grant_idx + LANE_W'(1);

    // Saturating next-cycle counter values; counter reset wins over increments.
    always_comb begin
        w_match_pop = '0;
        w_pass_pop  = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            w_match_pop = w_match_pop + 8'(w_qual_match[k]);
            w_pass_pop  = w_pass_pop + 8'(w_qual_pass[k]);
        end
        w_match_sum  = {1'b0, r_match_count} + 33'(w_match_pop);
        w_pass_sum   = {1'b0, r_pass_count} + 33'(w_pass_pop);
        w_match_next = w_match_sum[32] ? '1 : w_match_sum[31:0];
        w_pass_next  = w_pass_sum[32] ? '1 : w_pass_sum[31:0];
        if (i_counter_reset) begin
            w_match_next = '0;
            w_pass_next  = '0;
        end
    end

    // Stop request or target reached ends dispatch without a grant this cycle.
    assign w_stop_now = (r_state == StDispatch) &&
                        (i_stop || (i_match_target != 32'd0 && w_match_next >= i_match_target));

    // Round-robin search for the first idle lane starting at the pointer.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        if (r_state == StDispatch && !w_stop_now) begin
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                w_scan_idx = LANE_W'((32'(r_rr_ptr) + k) % NUM_LANES);
                if (!w_grant_valid && !r_outstanding[w_scan_idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_scan_idx;
                end
            end
        end
        w_grant_onehot = w_grant_valid ? (NUM_LANES'(1) << w_grant_idx) : '0;
    end

    // Lowest-index lane among this cycle's qualified matches.
    always_comb begin
        w_hit_lane = '0;
        for (int k = int'(NUM_LANES) - 1; k >= 0; k--) begin
            if (w_qual_match[k]) begin
                w_hit_lane = LANE_W'(k);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone: if (i_start) w_state_next = StDispatch;
            StDispatch:     if (w_stop_now) w_state_next = StDrain;
            StDrain: begin
                if (r_outstanding == '0 && i_lane_done == '0) w_state_next = StDone;
            end
            default:        w_state_next = StIdle;
        endcase
    end

    // State, seed, outstanding bits and round-robin pointer.
    always_ff @(posedge i_fclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_seed        <= '0;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= (r_outstanding & ~w_qual) | w_grant_onehot;
            if (w_start_ok) begin
                r_seed <= w_seed_start;
            end else if (w_grant_valid) begin
                r_seed   <= w_seed_inc;
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Remember the seed each lane is working on for first-hit reporting.
    always_ff @(posedge i_fclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned k = 0; k < NUM_LANES; k++) r_lane_seed[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                if (w_grant_onehot[k]) r_lane_seed[k] <= r_seed;
            end
        end
    end

    // Result counters, sticky first hit and spurious-done flag.
    always_ff @(posedge i_fclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_match_count     <= '0;
            r_pass_count      <= '0;
            r_first_hit_valid <= 1'b0;
            r_first_hit_lane  <= '0;
            r_first_hit_seed  <= '0;
            r_err_spurious    <= 1'b0;
        end else begin
            r_match_count <= w_match_next;
            r_pass_count  <= w_pass_next;
            if (i_counter_reset) begin
                r_first_hit_valid <= 1'b0;
                r_first_hit_lane  <= '0;
                r_first_hit_seed  <= '0;
                r_err_spurious    <= 1'b0;
            end else begin
                if (!r_first_hit_valid && w_hit_any) begin
                    r_first_hit_valid <= 1'b1;
                    r_first_hit_lane  <= w_hit_lane;
                    r_first_hit_seed  <= r_lane_seed[w_hit_lane];
                end
                if (|(i_lane_done & ~r_outstanding)) r_err_spurious <= 1'b1;
            end
        end
    end

    assign o_lane_start      = w_grant_onehot;
    assign o_lane_seed       = r_seed;
    assign o_running         = (r_state == StDispatch) || (r_state == StDrain);
    assign o_finished        = (r_state == StDone);
    assign o_first_hit_valid = r_first_hit_valid;
    assign o_first_hit_lane  = r_first_hit_lane;
    assign o_first_hit_seed  = r_first_hit_seed;
    assign o_err_spurious    = r_err_spurious;
    assign o_match_count     = r_match_count;
    assign o_pass_count      = r_pass_count;

endmodule
